// File: rtl/prog_loader.sv
// Copies ROM_DEPTH program words from ROM into the CPU instruction RAM after a start edge,
// one word every WORD_CYCLES clocks, and holds the CPU in reset until a full load completes.
module prog_loader #(
    parameter int unsigned ROM_DEPTH   = 256,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ROM_LATENCY = 2,
    parameter int unsigned WORD_CYCLES = 8
) (
    input  logic              clk,
    input  logic              s_reset,
    input  logic              start,
    input  logic              abort,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   word_count
);

    localparam int unsigned SLOT_W = (WORD_CYCLES > 1) ? $clog2(WORD_CYCLES) : 1;
    localparam int unsigned CNT_W  = ADDR_W + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state, state_n;
    logic [SLOT_W-1:0] slot, slot_n;
    logic [ADDR_W-1:0] index, index_n;
    logic              start_q;
    logic              start_edge;
    logic              rd_n, wr_n, capture;

    assign start_edge = start & ~start_q;

    // Next-state: terminal check happens before the index increment, so index never wraps.
    always_comb begin
        state_n = state;
        slot_n  = slot;
        index_n = index;
        case (state)
            S_LOAD: begin
                if (abort) begin
                    state_n = S_IDLE;
                end else if (slot == SLOT_W'(WORD_CYCLES - 1)) begin
                    slot_n = '0;
                    if (index == ADDR_W'(ROM_DEPTH - 1)) begin
                        state_n = S_DONE;
                    end else begin
                        index_n = index + ADDR_W'(1);
                    end
                end else begin
                    slot_n = slot + SLOT_W'(1);
                end
            end
            default: begin
                if (start_edge) begin
                    state_n = S_LOAD;
                    slot_n  = '0;
                    index_n = '0;
                end
            end
        endcase
    end

    // Strobes are decoded from the upcoming slot so they are registered yet aligned to it.
    assign rd_n    = (state_n == S_LOAD) && (slot_n == '0);
    assign wr_n    = (state_n == S_LOAD) && (slot_n == SLOT_W'(ROM_LATENCY + 1));
    assign capture = (state == S_LOAD) && (slot == SLOT_W'(ROM_LATENCY));

    always_ff @(posedge clk or posedge s_reset) begin
        if (s_reset) begin
            state      <= S_IDLE;
            slot       <= '0;
            index      <= '0;
            start_q    <= 1'b0;
            rom_en     <= 1'b0;
            rom_addr   <= '0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            cpu_hold   <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            word_count <= '0;
        end else begin
            state    <= state_n;
            slot     <= slot_n;
            index    <= index_n;
            start_q  <= start;
            rom_en   <= rd_n;
            ram_we   <= wr_n;
            busy     <= (state_n == S_LOAD);
            done     <= (state_n == S_DONE);
            cpu_hold <= (state_n != S_DONE);
            if (rd_n) begin
                rom_addr <= index_n;
            end
            if (capture) begin
                ram_wdata <= rom_data;
                ram_addr  <= index;
            end
            if (state != S_LOAD && state_n == S_LOAD) begin
                word_count <= '0;
            end else if (wr_n) begin
                word_count <= word_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: default instance plus a small-parameter instance,
// each fed by a latency-accurate ROM model and checked write-by-write.
module tb_prog_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] rom_fn(input logic [7:0] a);
        return {8'hC3, a, ~a, a ^ 8'h5A};
    endfunction

    // Default instance
    logic        s_reset, start, abort;
    logic        rom_en, ram_we, cpu_hold, busy, done;
    logic [7:0]  rom_addr, ram_addr;
    logic [31:0] rom_data, ram_wdata, rom_p1;
    logic [8:0]  word_count;

    prog_loader dut (
        .clk(clk), .s_reset(s_reset), .start(start), .abort(abort),
        .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .word_count(word_count)
    );

    // Two-clock ROM
    always @(posedge clk) begin
        if (rom_en) rom_p1 <= rom_fn(rom_addr);
        rom_data <= rom_p1;
    end

    // Small instance: depth 4, latency 1, 3 clocks per word
    logic        s_start;
    logic        s_rom_en, s_ram_we, s_cpu_hold, s_busy, s_done;
    logic [1:0]  s_rom_addr, s_ram_addr;
    logic [31:0] s_rom_data, s_ram_wdata;
    logic [2:0]  s_word_count;
    logic        s_abort = 1'b0;

    prog_loader #(.ROM_DEPTH(4), .ADDR_W(2), .DATA_W(32), .ROM_LATENCY(1), .WORD_CYCLES(3)) dut_s (
        .clk(clk), .s_reset(s_reset), .start(s_start), .abort(s_abort),
        .rom_en(s_rom_en), .rom_addr(s_rom_addr), .rom_data(s_rom_data),
        .ram_we(s_ram_we), .ram_addr(s_ram_addr), .ram_wdata(s_ram_wdata),
        .cpu_hold(s_cpu_hold), .busy(s_busy), .done(s_done), .word_count(s_word_count)
    );

    always @(posedge clk) begin
        if (s_rom_en) s_rom_data <= rom_fn(8'(s_rom_addr));
    end

    // Write monitors: every strobe must be the next word, with the right data, on its slot
    int t0 = 0, exp_k = 0, nwr = 0;
    int s_t0 = 0, s_k = 0, s_nwr = 0;

    always @(negedge clk) begin
        if (ram_we) begin
            check("wr_addr", 64'(ram_addr), 64'(exp_k));
            check("wr_data", 64'(ram_wdata), 64'(rom_fn(8'(exp_k))));
            check("wr_time", 64'(cyc), 64'(t0 + 1 + 8 * exp_k + 3));
            exp_k++;
            nwr++;
        end
        if (s_ram_we) begin
            check("s_wr_addr", 64'(s_ram_addr), 64'(s_k));
            check("s_wr_data", 64'(s_ram_wdata), 64'(rom_fn(8'(s_k))));
            check("s_wr_time", 64'(cyc), 64'(s_t0 + 1 + 3 * s_k + 2));
            s_k++;
            s_nwr++;
        end
    end

    // Leaves start high; clock T is the interval in which start first reads high
    task automatic do_start();
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        t0    = cyc;
        exp_k = 0;
        nwr   = 0;
    endtask

    task automatic wait_done(input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (done) begin
                at = cyc;
                return;
            end
        end
        check("done_timeout", 64'(done), 64'(1));
    endtask

    task automatic wait_writes(input int n, input int limit);
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            #1;
            if (nwr >= n) return;
        end
        check("write_timeout", 64'(nwr), 64'(n));
    endtask

    task automatic check_full_load(input string tag, input int at);
        check({tag, "_time"},  64'(at), 64'(t0 + 2049));
        check({tag, "_done"},  64'(done), 64'(1));
        check({tag, "_hold"},  64'(cpu_hold), 64'(0));
        check({tag, "_busy"},  64'(busy), 64'(0));
        check({tag, "_wc"},    64'(word_count), 64'(256));
        check({tag, "_nwr"},   64'(nwr), 64'(256));
    endtask

    int tdone;

    initial begin
        s_reset = 1'b1;
        start   = 1'b0;
        abort   = 1'b0;
        s_start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rom_en", 64'(rom_en), 64'(0));
        check("rst_ram_we", 64'(ram_we), 64'(0));
        check("rst_hold",   64'(cpu_hold), 64'(1));
        check("rst_busy",   64'(busy), 64'(0));
        check("rst_done",   64'(done), 64'(0));
        check("rst_wc",     64'(word_count), 64'(0));
        check("rst_addr",   64'(ram_addr), 64'(0));
        s_reset = 1'b0;
        repeat (3) @(negedge clk);

        // Basic load with timing, start released shortly after the edge
        do_start();
        @(negedge clk);
        check("a_busy", 64'(busy), 64'(1));
        check("a_hold", 64'(cpu_hold), 64'(1));
        check("a_done", 64'(done), 64'(0));
        check("a_rom_en", 64'(rom_en), 64'(1));
        repeat (5) @(negedge clk);
        start = 1'b0;
        wait_done(3000, tdone);
        check_full_load("a", tdone);

        // start held high for 3000 clocks: exactly one (re)load
        do_start();
        @(negedge clk);
        check("b_hold_reassert", 64'(cpu_hold), 64'(1));
        check("b_done_clear", 64'(done), 64'(0));
        repeat (3000) @(negedge clk);
        check("b_nwr",  64'(nwr), 64'(256));
        check("b_done", 64'(done), 64'(1));
        check("b_wc",   64'(word_count), 64'(256));
        start = 1'b0;

        // Start edge during a load is ignored
        do_start();
        @(negedge clk);
        start = 1'b0;
        wait_writes(100, 1000);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(3000, tdone);
        check_full_load("c", tdone);

        // Abort after 37 writes
        do_start();
        @(negedge clk);
        start = 1'b0;
        wait_writes(37, 1000);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("d_busy",   64'(busy), 64'(0));
        check("d_done",   64'(done), 64'(0));
        check("d_hold",   64'(cpu_hold), 64'(1));
        check("d_wc",     64'(word_count), 64'(37));
        check("d_rom_en", 64'(rom_en), 64'(0));
        repeat (50) @(negedge clk);
        check("d_nwr_after", 64'(nwr), 64'(37));
        check("d_idle_busy", 64'(busy), 64'(0));
        abort = 1'b1;
        repeat (2) @(negedge clk);
        abort = 1'b0;
        check("d_idle_abort_busy", 64'(busy), 64'(0));
        do_start();
        @(negedge clk);
        start = 1'b0;
        wait_done(3000, tdone);
        check_full_load("d", tdone);

        // Reset mid-load
        do_start();
        @(negedge clk);
        start = 1'b0;
        wait_writes(200, 3000);
        s_reset = 1'b1;
        #1;
        check("e_hold",   64'(cpu_hold), 64'(1));
        check("e_busy",   64'(busy), 64'(0));
        check("e_done",   64'(done), 64'(0));
        check("e_wc",     64'(word_count), 64'(0));
        check("e_ram_we", 64'(ram_we), 64'(0));
        check("e_rom_en", 64'(rom_en), 64'(0));
        check("e_wdata",  64'(ram_wdata), 64'(0));
        check("e_raddr",  64'(rom_addr), 64'(0));
        repeat (3) @(negedge clk);
        s_reset = 1'b0;
        repeat (30) @(negedge clk);
        check("e_nwr_after", 64'(nwr), 64'(200));
        check("e_busy_after", 64'(busy), 64'(0));
        do_start();
        @(negedge clk);
        start = 1'b0;
        wait_done(3000, tdone);
        check_full_load("e", tdone);

        // Small-parameter instance
        @(negedge clk);
        s_start = 1'b1;
        s_t0    = cyc;
        tdone   = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (s_done) begin
                tdone = cyc;
                break;
            end
        end
        check("s_time", 64'(tdone), 64'(s_t0 + 13));
        check("s_wc",   64'(s_word_count), 64'(4));
        check("s_nwr",  64'(s_nwr), 64'(4));
        check("s_hold", 64'(s_cpu_hold), 64'(0));
        check("s_busy", 64'(s_busy), 64'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
